// File: rtl/axi_lite_to_reg_if.sv
// Bus bundle for the AXI4-Lite to register-bus bridge. Signal suffixes are
// named from the bridge's point of view; the master modport is the environment.
interface axi_lite_to_reg_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] aw_addr_i;
  logic                  aw_valid_i;
  logic                  aw_ready_o;
  logic [DATA_WIDTH-1:0] w_data_i;
  logic [STRB_WIDTH-1:0] w_strb_i;
  logic                  w_valid_i;
  logic                  w_ready_o;
  logic [1:0]            b_resp_o;
  logic                  b_valid_o;
  logic                  b_ready_i;
  logic [ADDR_WIDTH-1:0] ar_addr_i;
  logic                  ar_valid_i;
  logic                  ar_ready_o;
  logic [DATA_WIDTH-1:0] r_data_o;
  logic [1:0]            r_resp_o;
  logic                  r_valid_o;
  logic                  r_ready_i;
  logic [ADDR_WIDTH-1:0] reg_addr_o;
  logic                  reg_write_o;
  logic [DATA_WIDTH-1:0] reg_wdata_o;
  logic [STRB_WIDTH-1:0] reg_wstrb_o;
  logic                  reg_valid_o;
  logic [DATA_WIDTH-1:0] reg_rdata_i;
  logic                  reg_error_i;
  logic                  reg_ready_i;

  modport slave (
    input  aw_addr_i, aw_valid_i, w_data_i, w_strb_i, w_valid_i, b_ready_i,
           ar_addr_i, ar_valid_i, r_ready_i, reg_rdata_i, reg_error_i, reg_ready_i,
    output aw_ready_o, w_ready_o, b_resp_o, b_valid_o, ar_ready_o, r_data_o,
           r_resp_o, r_valid_o, reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o,
           reg_valid_o
  );

  modport master (
    output aw_addr_i, aw_valid_i, w_data_i, w_strb_i, w_valid_i, b_ready_i,
           ar_addr_i, ar_valid_i, r_ready_i, reg_rdata_i, reg_error_i, reg_ready_i,
    input  aw_ready_o, w_ready_o, b_resp_o, b_valid_o, ar_ready_o, r_data_o,
           r_resp_o, r_valid_o, reg_addr_o, reg_write_o, reg_wdata_o, reg_wstrb_o,
           reg_valid_o
  );
endinterface

// File: rtl/axi_lite_to_reg.sv
// AXI4-Lite slave to single-phase register-bus master; one transaction in
// flight, round-robin between simultaneous read and write requests.
//
// state   | meaning
// IDLE    | waiting for AW+W or AR, grants one
// REG_WR  | register-bus write request outstanding
// REG_RD  | register-bus read request outstanding
// WR_RESP | write response waiting for b_ready_i
// RD_RESP | read data/response waiting for r_ready_i
module axi_lite_to_reg #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  axi_lite_to_reg_if.slave    bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] REG_WR  = 3'd1;
  localparam logic [2:0] REG_RD  = 3'd2;
  localparam logic [2:0] WR_RESP = 3'd3;
  localparam logic [2:0] RD_RESP = 3'd4;

  logic [2:0]            state_q, state_d;
  logic                  wr_prio_q, wr_prio_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [1:0]            rresp_q, rresp_d;

  logic wr_elig, rd_elig, is_idle, grant_wr, grant_rd, reg_valid, reg_done;
  logic [1:0] resp_in;

  assign wr_elig  = bus.aw_valid_i & bus.w_valid_i;
  assign rd_elig  = bus.ar_valid_i;
  // readies are combinational, so gate them with reset as well
  assign is_idle  = (state_q == IDLE) & rst_ni;
  assign grant_wr = is_idle & wr_elig & (wr_prio_q | ~rd_elig);
  assign grant_rd = is_idle & rd_elig & (~wr_prio_q | ~wr_elig);
  assign reg_valid = (state_q == REG_WR) | (state_q == REG_RD);
  assign reg_done  = reg_valid & bus.reg_ready_i;
  assign resp_in   = bus.reg_error_i ? 2'b10 : 2'b00;

  always_comb begin
    state_d   = state_q;
    wr_prio_d = wr_prio_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    write_d   = write_q;
    rdata_d   = rdata_q;
    bresp_d   = bresp_q;
    rresp_d   = rresp_q;
    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d   = REG_WR;
          wr_prio_d = 1'b0;
          addr_d    = bus.aw_addr_i;
          wdata_d   = bus.w_data_i;
          wstrb_d   = bus.w_strb_i;
          write_d   = 1'b1;
        end else if (grant_rd) begin
          state_d   = REG_RD;
          wr_prio_d = 1'b1;
          addr_d    = bus.ar_addr_i;
          wdata_d   = '0;
          wstrb_d   = '0;
          write_d   = 1'b0;
        end
      end
      REG_WR: begin
        if (reg_done) begin
          state_d = WR_RESP;
          bresp_d = resp_in;
        end
      end
      REG_RD: begin
        if (reg_done) begin
          state_d = RD_RESP;
          rresp_d = resp_in;
          rdata_d = bus.reg_rdata_i;
        end
      end
      WR_RESP: if (bus.b_ready_i) state_d = IDLE;
      RD_RESP: if (bus.r_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      wr_prio_q <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      wr_prio_q <= wr_prio_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      write_q   <= write_d;
      rdata_q   <= rdata_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
    end
  end

  assign bus.aw_ready_o  = grant_wr;
  assign bus.w_ready_o   = grant_wr;
  assign bus.ar_ready_o  = grant_rd;
  assign bus.reg_valid_o = reg_valid;
  assign bus.reg_addr_o  = addr_q;
  assign bus.reg_wdata_o = wdata_q;
  assign bus.reg_wstrb_o = wstrb_q;
  assign bus.reg_write_o = write_q;
  assign bus.b_valid_o   = (state_q == WR_RESP);
  assign bus.b_resp_o    = bresp_q;
  assign bus.r_valid_o   = (state_q == RD_RESP);
  assign bus.r_resp_o    = rresp_q;
  assign bus.r_data_o    = rdata_q;
endmodule

// File: tb/tb_axi_lite_to_reg.sv
// Bench for axi_lite_to_reg: directed scenarios plus randomized AXI/reg-bus
// traffic, all checked each cycle against a transaction-level model.
module tb_axi_lite_to_reg;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  axi_lite_to_reg_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  axi_lite_to_reg #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // transaction-level model: 0 = free, 1 = request on reg bus, 2 = response owed
  int          m_phase;
  bit          m_last_wr;
  bit          m_wr;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  bit          aw_hs, w_hs, ar_hs;
  int          regv_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_last_wr = 0; m_wr = 0;
    m_addr = '0; m_wdata = '0; m_wstrb = '0; m_rdata = '0;
    m_bresp = 2'b00; m_rresp = 2'b00;
  endtask

  task automatic model_check();
    bit gw, gr, wel, rel;
    gw = 0; gr = 0;
    if (m_phase == 0) begin
      wel = bus.aw_valid_i && bus.w_valid_i;
      rel = bus.ar_valid_i;
      if (wel && rel) begin gw = !m_last_wr; gr = m_last_wr; end
      else begin gw = wel; gr = rel; end
    end
    chk("aw_ready", bus.aw_ready_o, gw);
    chk("w_ready", bus.w_ready_o, gw);
    chk("ar_ready", bus.ar_ready_o, gr);
    chk("reg_valid", bus.reg_valid_o, m_phase == 1);
    if (m_phase == 1) begin
      chk("reg_addr", bus.reg_addr_o, m_addr);
      chk("reg_write", bus.reg_write_o, m_wr);
      chk("reg_wdata", bus.reg_wdata_o, m_wdata);
      chk("reg_wstrb", bus.reg_wstrb_o, m_wstrb);
    end
    chk("b_valid", bus.b_valid_o, m_phase == 2 && m_wr);
    chk("r_valid", bus.r_valid_o, m_phase == 2 && !m_wr);
    chk("b_resp", bus.b_resp_o, m_bresp);
    chk("r_resp", bus.r_resp_o, m_rresp);
    chk("r_data", bus.r_data_o, m_rdata);
    aw_hs = bus.aw_valid_i && bus.aw_ready_o;
    w_hs  = bus.w_valid_i && bus.w_ready_o;
    ar_hs = bus.ar_valid_i && bus.ar_ready_o;
    case (m_phase)
      0: if (gw) begin
           m_wr = 1; m_last_wr = 1; m_phase = 1;
           m_addr = bus.aw_addr_i; m_wdata = bus.w_data_i; m_wstrb = bus.w_strb_i;
         end else if (gr) begin
           m_wr = 0; m_last_wr = 0; m_phase = 1;
           m_addr = bus.ar_addr_i; m_wdata = '0; m_wstrb = '0;
         end
      1: if (bus.reg_ready_i) begin
           m_phase = 2;
           if (m_wr) m_bresp = bus.reg_error_i ? 2'b10 : 2'b00;
           else begin
             m_rresp = bus.reg_error_i ? 2'b10 : 2'b00;
             m_rdata = bus.reg_rdata_i;
           end
         end
      default: if (m_wr ? bus.b_ready_i : bus.r_ready_i) m_phase = 0;
    endcase
  endtask

  // one clock: check at the falling edge, return 1 time unit after the rising edge,
  // withdrawing any AXI valid that was just accepted
  task automatic tick();
    @(negedge clk_i);
    model_check();
    @(posedge clk_i);
    #1;
    if (aw_hs) bus.aw_valid_i = 0;
    if (w_hs)  bus.w_valid_i = 0;
    if (ar_hs) bus.ar_valid_i = 0;
  endtask

  task automatic clear_inputs();
    bus.aw_addr_i = '0; bus.aw_valid_i = 0; bus.w_data_i = '0; bus.w_strb_i = '0;
    bus.w_valid_i = 0; bus.b_ready_i = 0; bus.ar_addr_i = '0; bus.ar_valid_i = 0;
    bus.r_ready_i = 0; bus.reg_rdata_i = '0; bus.reg_error_i = 0; bus.reg_ready_i = 0;
  endtask

  task automatic set_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.aw_addr_i = a; bus.aw_valid_i = 1;
    bus.w_data_i = d; bus.w_strb_i = s; bus.w_valid_i = 1;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst reg_valid", bus.reg_valid_o, 1'b0);
    chk("rst reg_addr", bus.reg_addr_o, 32'h0);
    chk("rst b_valid", bus.b_valid_o, 1'b0);
    rst_ni = 1;

    // tie straight out of reset: write first, then read on the repeated tie
    set_write(32'h0000_0100, 32'h1111_2222, 4'hF);
    bus.ar_addr_i = 32'h0000_0200; bus.ar_valid_i = 1;
    bus.reg_ready_i = 1; bus.b_ready_i = 1; bus.r_ready_i = 1;
    #1;
    chk("tie1 aw_ready", bus.aw_ready_o, 1'b1);
    chk("tie1 ar_ready", bus.ar_ready_o, 1'b0);
    repeat (3) tick();
    set_write(32'h0000_0104, 32'h3333_4444, 4'h3);
    #1;
    chk("tie2 ar_ready", bus.ar_ready_o, 1'b1);
    chk("tie2 aw_ready", bus.aw_ready_o, 1'b0);
    repeat (6) tick();
    clear_inputs();
    tick();

    // single write with reg_ready tied high
    set_write(32'h10, 32'hDEADBEEF, 4'hF);
    bus.reg_ready_i = 1;
    tick();
    chk("wr reg_valid N+1", bus.reg_valid_o, 1'b1);
    chk("wr reg_write", bus.reg_write_o, 1'b1);
    chk("wr reg_addr", bus.reg_addr_o, 32'h10);
    chk("wr reg_wdata", bus.reg_wdata_o, 32'hDEADBEEF);
    tick();
    chk("wr b_valid N+2", bus.b_valid_o, 1'b1);
    chk("wr b_resp", bus.b_resp_o, 2'b00);
    chk("wr reg_valid off", bus.reg_valid_o, 1'b0);
    bus.b_ready_i = 1;
    tick();
    clear_inputs();

    // read with three wait states
    bus.ar_addr_i = 32'h20; bus.ar_valid_i = 1;
    tick();
    regv_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.reg_valid_o && bus.reg_addr_o == 32'h20) regv_cnt++;
      if (i == 3) begin bus.reg_ready_i = 1; bus.reg_rdata_i = 32'h12345678; end
      tick();
    end
    bus.reg_ready_i = 0;
    chk("rd valid cycles", regv_cnt, 4);
    chk("rd r_valid", bus.r_valid_o, 1'b1);
    chk("rd r_data", bus.r_data_o, 32'h12345678);
    chk("rd r_resp", bus.r_resp_o, 2'b00);
    bus.r_ready_i = 1;
    tick();
    clear_inputs();

    // AW without W is never accepted; concurrent AR proceeds
    bus.aw_addr_i = 32'h44; bus.aw_valid_i = 1;
    bus.ar_addr_i = 32'h48; bus.ar_valid_i = 1;
    bus.reg_ready_i = 1; bus.r_ready_i = 1; bus.b_ready_i = 1;
    for (int i = 0; i < 5; i++) begin
      chk("aw-only aw_ready", bus.aw_ready_o, 1'b0);
      tick();
    end
    bus.w_data_i = 32'hCAFE0001; bus.w_strb_i = 4'h5; bus.w_valid_i = 1;
    #1;
    chk("aw+w aw_ready", bus.aw_ready_o, 1'b1);
    repeat (3) tick();
    clear_inputs();

    // error responses, with b_ready held low
    set_write(32'h50, 32'h0, 4'h1);
    bus.reg_ready_i = 1; bus.reg_error_i = 1;
    repeat (2) tick();
    for (int i = 0; i < 4; i++) begin
      chk("err b_valid hold", bus.b_valid_o, 1'b1);
      chk("err b_resp hold", bus.b_resp_o, 2'b10);
      tick();
    end
    bus.b_ready_i = 1;
    tick();
    bus.b_ready_i = 0;
    bus.ar_addr_i = 32'h54; bus.ar_valid_i = 1;
    repeat (2) tick();
    chk("err r_resp", bus.r_resp_o, 2'b10);
    bus.r_ready_i = 1;
    tick();
    clear_inputs();

    // asynchronous reset while a read is on the register bus
    bus.ar_addr_i = 32'h30; bus.ar_valid_i = 1;
    repeat (2) tick();
    chk("pre-rst reg_valid", bus.reg_valid_o, 1'b1);
    bus.ar_addr_i = 32'h38; bus.ar_valid_i = 1;
    #2 rst_ni = 0;
    #1;
    chk("async rst reg_valid", bus.reg_valid_o, 1'b0);
    chk("async rst ar_ready", bus.ar_ready_o, 1'b0);
    chk("async rst r_valid", bus.r_valid_o, 1'b0);
    chk("async rst reg_addr", bus.reg_addr_o, 32'h0);
    clear_inputs();
    model_reset();
    @(posedge clk_i);
    #1 rst_ni = 1;
    bus.ar_addr_i = 32'h34; bus.ar_valid_i = 1;
    bus.reg_ready_i = 1; bus.reg_rdata_i = 32'hA5A5_0F0F;
    repeat (2) tick();
    chk("post-rst r_valid", bus.r_valid_o, 1'b1);
    chk("post-rst r_data", bus.r_data_o, 32'hA5A5_0F0F);
    bus.r_ready_i = 1;
    tick();
    clear_inputs();

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if (!bus.aw_valid_i && $urandom_range(0, 3) == 0) begin
        bus.aw_valid_i = 1; bus.aw_addr_i = $urandom;
      end
      if (!bus.w_valid_i && $urandom_range(0, 3) == 0) begin
        bus.w_valid_i = 1; bus.w_data_i = $urandom; bus.w_strb_i = 4'($urandom_range(0, 15));
      end
      if (!bus.ar_valid_i && $urandom_range(0, 2) == 0) begin
        bus.ar_valid_i = 1; bus.ar_addr_i = $urandom;
      end
      bus.b_ready_i   = 1'($urandom_range(0, 1));
      bus.r_ready_i   = 1'($urandom_range(0, 1));
      bus.reg_ready_i = ($urandom_range(0, 2) != 0);
      bus.reg_error_i = ($urandom_range(0, 3) == 0);
      bus.reg_rdata_i = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
